// File: rtl/gcd_requester.sv
// Host-side initiator for the subtraction GCD core: accepts operand pairs, launches the
// core, short-circuits zero operands, guards against a silent core, and returns the result.
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic             out_timeout,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy,
  output logic [CNTW-1:0]  done_count
);

  // Timer counts 0..TIMEOUT-1, which fits in clog2(TIMEOUT) bits.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, r_opb, r_gcd;
  logic [WIDTH-1:0] w_opa_nxt, w_opb_nxt, w_gcd_nxt;
  logic             r_zero, r_timeout, w_zero_nxt, w_timeout_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic [CNTW-1:0]  r_done_cnt, w_done_cnt_nxt;
  logic             w_timer_last;

  assign w_timer_last = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opa      <= '0;
      r_opb      <= '0;
      r_gcd      <= '0;
      r_zero     <= 1'b0;
      r_timeout  <= 1'b0;
      r_timer    <= '0;
      r_done_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_opa      <= w_opa_nxt;
      r_opb      <= w_opb_nxt;
      r_gcd      <= w_gcd_nxt;
      r_zero     <= w_zero_nxt;
      r_timeout  <= w_timeout_nxt;
      r_timer    <= w_timer_nxt;
      r_done_cnt <= w_done_cnt_nxt;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the offered data stays stable until the transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_opa_nxt      = r_opa;
    w_opb_nxt      = r_opb;
    w_gcd_nxt      = r_gcd;
    w_zero_nxt     = r_zero;
    w_timeout_nxt  = r_timeout;
    w_timer_nxt    = r_timer;
    w_done_cnt_nxt = r_done_cnt;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    core_start     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_opa_nxt = in_a;
          w_opb_nxt = in_b;
          if ((in_a != '0) && (in_b != '0)) begin
            w_state_nxt = S_ISSUE;
          end else begin
            // A zero operand would spin the core forever; gcd(x,0)=x.
            w_gcd_nxt   = in_a | in_b;
            w_zero_nxt  = ((in_a | in_b) == '0);
            w_state_nxt = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        core_start  = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) begin
          w_gcd_nxt   = core_result;
          w_state_nxt = S_RESP;
        end else if (w_timer_last) begin
          w_gcd_nxt     = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_RESP;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_zero_nxt     = 1'b0;
          w_timeout_nxt  = 1'b0;
          w_done_cnt_nxt = r_done_cnt + CNTW'(1);
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_gcd     = r_gcd;
  assign out_zero    = r_zero;
  assign out_timeout = r_timeout;
  assign core_a      = r_opa;
  assign core_b      = r_opb;
  assign busy        = (r_state != S_IDLE);
  assign done_count  = r_done_cnt;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD core with programmable response delay,
// cycle-level reference model with an expected-result queue, and directed vectors.
module tb_gcd_requester;

  localparam int W  = 8;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  out_gcd;
  logic          out_zero, out_timeout;
  logic          core_start;
  logic [W-1:0]  core_a, core_b;
  logic          core_ready;
  logic [W-1:0]  core_result;
  logic          busy;
  logic [CW-1:0] done_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int core_delay = 0;  // 0 = core never answers
  int stray_cnt = 0;

  gcd_requester #(.WIDTH(W), .TIMEOUT(TO), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_zero(out_zero), .out_timeout(out_timeout),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_ready(core_ready), .core_result(core_result),
    .busy(busy), .done_count(done_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  // ---------------- helpers / model ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Result packed as {timeout, zero, gcd}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int d);
    if (a == '0 || b == '0) return {1'b0, ((a | b) == '0), a | b};
    if (d == 0 || d > TO) return {1'b1, 1'b0, {W{1'b0}}};
    return {1'b0, 1'b0, gcd_f(a, b)};
  endfunction

  // ---------------- behavioural GCD core ----------------
  initial begin
    int c_cnt;
    int c_stray;
    logic c_load, r_at;
    logic [W-1:0] c_g;
    c_cnt = 0;
    c_stray = 0;
    c_load = 1'b0;
    c_g = '0;
    core_ready = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      r_at = rst;
      #2;
      core_ready = 1'b0;
      core_result = '0;
      if (r_at) begin
        c_cnt = 0;
        c_load = 1'b0;
      end else begin
        if (c_load) begin
          c_g = gcd_f(core_a, core_b);
          c_load = 1'b0;
        end
        if (c_cnt > 0) begin
          c_cnt--;
          if (c_cnt == 0) begin
            core_ready = 1'b1;
            core_result = c_g;
          end
        end
        if (stray_cnt != c_stray) begin
          c_stray = stray_cnt;
          core_ready = 1'b1;
          core_result = 8'hA5;
        end
        if (core_start) begin
          c_cnt = core_delay;
          c_load = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [W+1:0] exp_q[$];

  initial begin
    logic pend, pv, pacc;
    logic [W+1:0] pres, e;
    logic [W-1:0] m_opa, m_opb;
    int t_valid, t_start, exp_done;
    pend = 1'b0; pv = 1'b0; pacc = 1'b0; pres = '0;
    m_opa = '0; m_opb = '0;
    t_valid = 0; t_start = -1; exp_done = 0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("in_ready", 32'(in_ready), 32'(!pend));
        chk("busy", 32'(busy), 32'(pend));
        chk("out_valid", 32'(out_valid), 32'(pend && cyc >= t_valid));
        chk("core_start", 32'(core_start), 32'(pend && cyc == t_start));
        chk("core_a", 32'(core_a), 32'(m_opa));
        chk("core_b", 32'(core_b), 32'(m_opb));
        chk("done_count", 32'(done_count), 32'(exp_done));
        if (pv && !pacc && out_valid)
          chk("resp_stable", 32'({out_timeout, out_zero, out_gcd}), 32'(pres));
        pv = out_valid;
        pacc = out_valid && out_ready;
        pres = {out_timeout, out_zero, out_gcd};
        if (rst) begin
          pend = 1'b0;
          exp_q.delete();
          exp_done = 0;
          m_opa = '0;
          m_opb = '0;
          pv = 1'b0;
        end else begin
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_result", 32'(1), 32'(0));
            end else begin
              e = exp_q.pop_front();
              chk("result", 32'({out_timeout, out_zero, out_gcd}), 32'(e));
            end
            pend = 1'b0;
            exp_done = (exp_done + 1) % (1 << CW);
          end
          if (in_valid && in_ready) begin
            m_opa = in_a;
            m_opb = in_b;
            exp_q.push_back(model(in_a, in_b, core_delay));
            pend = 1'b1;
            if (in_a != '0 && in_b != '0) begin
              t_start = cyc + 1;
              t_valid = (core_delay == 0 || core_delay > TO) ? cyc + 2 + TO
                                                             : cyc + 2 + core_delay;
            end else begin
              t_start = -1;
              t_valid = cyc + 1;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_wait_expired", 32'(0), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a;
    in_b = ~b;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                     input int hold, input logic [W-1:0] eg, input logic ez, input logic et);
    int v;
    logic done;
    v = 0;
    done = 1'b0;
    core_delay = d;
    out_ready = (hold == 0);
    accept(a, b);
    for (int i = 0; i < 200 && !done; i++) begin
      if (out_valid) begin
        v++;
        if (v > hold) begin
          out_ready = 1'b1;
          chk("lit_gcd", 32'(out_gcd), 32'(eg));
          chk("lit_zero", 32'(out_zero), 32'(ez));
          chk("lit_timeout", 32'(out_timeout), 32'(et));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    if (!done) chk("result_wait_expired", 32'(0), 32'(1));
    out_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_core_start", 32'(core_start), 32'(0));
    chk("reset_done_count", 32'(done_count), 32'(0));
    chk("reset_flags", 32'({out_zero, out_timeout}), 32'(0));

    run(8'd48, 8'd18, 5, 0, 8'd6, 1'b0, 1'b0);
    chk("done_after_first", 32'(done_count), 32'(1));
    run(8'd0, 8'd35, 3, 0, 8'd35, 1'b0, 1'b0);
    run(8'd0, 8'd0, 3, 0, 8'd0, 1'b1, 1'b0);
    run(8'd35, 8'd0, 3, 1, 8'd35, 1'b0, 1'b0);
    run(8'd100, 8'd75, 0, 0, 8'd0, 1'b0, 1'b1);   // silent core
    run(8'd255, 8'd1, 2, 5, 8'd1, 1'b0, 1'b0);    // sink stalls 5 cycles
    run(8'd21, 8'd14, TO, 0, 8'd7, 1'b0, 1'b0);   // ready on the last WAIT cycle
    run(8'd21, 8'd14, TO + 1, 2, 8'd0, 1'b0, 1'b1); // late ready lands in RESP
    run(8'd7, 8'd7, 1, 0, 8'd7, 1'b0, 1'b0);
    run(8'd91, 8'd65, 4, 3, 8'd13, 1'b0, 1'b0);

    stray_cnt++;                                  // stray core pulse while idle
    repeat (4) @(posedge clk);
    #1;
    chk("stray_idle_valid", 32'(out_valid), 32'(0));

    core_delay = 0;
    accept(8'd9, 8'd6);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'(1));
    chk("pre_rst_done", 32'(done_count), 32'(10));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_done_count", 32'(done_count), 32'(0));
    run(8'd12, 8'd8, 3, 0, 8'd4, 1'b0, 1'b0);
    chk("done_after_rst", 32'(done_count), 32'(1));

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
